maze_bram_arbiter: RTL and testbench



---
 rtl/maze_pkg.sv | 10 +
 rtl/maze_bram_arbiter_if.sv | 21 ++
 rtl/maze_bram_arbiter_rr_pick.sv | 21 ++
 rtl/maze_bram_arbiter.sv | 100 ++++++++++
 tb/tb_maze_bram_arbiter.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// maze_pkg: shared maze geometry, BRAM word layout and arbiter state encoding
package maze_pkg;
  localparam int MAZE_SIZE = 16;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 9;
  localparam int WALL_BIT = 0;
  localparam int COLL_LSB = 1;
  localparam int COLL_MSB = 3;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/maze_bram_arbiter_if.sv
// maze_bram_arbiter_if: requester bus plus single BRAM port seen by the maze arbiter
interface maze_bram_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 9
);
  logic [NUM_REQ-1:0] req, req_we, gnt, rvalid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_din;
  logic [DATA_W-1:0] rdata, bram_din, bram_dout;
  logic [ADDR_W-1:0] bram_addr;
  logic bram_en, bram_we;
  modport slave (
    input req, req_we, req_addr, req_din, bram_dout,
    output gnt, rvalid, rdata, bram_en, bram_we, bram_addr, bram_din
  );
  modport master (
    output req, req_we, req_addr, req_din, bram_dout,
    input gnt, rvalid, rdata, bram_en, bram_we, bram_addr, bram_din
  );
endinterface

// File: rtl/maze_bram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner select starting at ptr
module rr_pick #(
  parameter int N = 3,
  parameter int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] win,
  output logic         any_req
);
  function automatic logic [W-1:0] wrap(int s);
    return W'(s >= N ? s - N : s);
  endfunction
  // scan from the farthest offset back toward ptr so the closest request wins
  always_comb begin
    win = ptr;
    for (int k = N - 1; k >= 0; k--)
      if (req[wrap(int'(ptr) + k)]) win = wrap(int'(ptr) + k);
  end
  assign any_req = |req;
endmodule

// File: rtl/maze_bram_arbiter.sv
// maze_bram_arbiter: serialises requester accesses to the single-port maze BRAM
module maze_bram_arbiter import maze_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 9,
  parameter int READ_LAT = 1
) (
  input  logic mvmt_clk,
  input  logic reset,
  input  logic en,
  maze_bram_arbiter_if.slave bus,
  output logic busy
);
  localparam int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(READ_LAT + 1);
  arb_state_t state, state_n;
  logic [IDX_W-1:0] sel, sel_n, rr_ptr, rr_n, pick_w;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NUM_REQ-1:0] gnt_n, rvalid_n;
  logic [DATA_W-1:0] rdata_n, din_n;
  logic [ADDR_W-1:0] addr_n;
  logic en_n, we_n, pick_any;
  rr_pick #(.N(NUM_REQ), .W(IDX_W)) u_pick (
    .req(bus.req),
    .ptr(rr_ptr),
    .win(pick_w),
    .any_req(pick_any)
  );
  // next state and next registered outputs; BRAM address/data hold between accesses
  always_comb begin
    state_n = state;
    sel_n = sel;
    rr_n = rr_ptr;
    cnt_n = cnt;
    gnt_n = '0;
    rvalid_n = '0;
    rdata_n = bus.rdata;
    en_n = bus.bram_en;
    we_n = bus.bram_we;
    addr_n = bus.bram_addr;
    din_n = bus.bram_din;
    case (state)
      IDLE: if (en && pick_any) begin
        state_n = ACCESS;
        sel_n = pick_w;
        rr_n = (pick_w == IDX_W'(NUM_REQ - 1)) ? '0 : pick_w + 1'b1;
        gnt_n[pick_w] = 1'b1;
        en_n = 1'b1;
        we_n = bus.req_we[pick_w];
        addr_n = bus.req_addr[pick_w*ADDR_W +: ADDR_W];
        din_n = bus.req_din[pick_w*DATA_W +: DATA_W];
      end
      ACCESS: begin
        en_n = 1'b0;
        we_n = 1'b0;
        cnt_n = bus.bram_we ? cnt : CNT_W'(READ_LAT - 1);
        state_n = bus.bram_we ? IDLE : (READ_LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_n = cnt - 1'b1;
        state_n = (cnt == CNT_W'(1)) ? RESP : WAIT;
      end
      RESP: begin
        rdata_n = bus.bram_dout;
        rvalid_n[sel] = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // register state and every output; asynchronous reset aborts any transaction
  always_ff @(posedge mvmt_clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      sel <= '0;
      rr_ptr <= '0;
      cnt <= '0;
      bus.gnt <= '0;
      bus.rvalid <= '0;
      bus.rdata <= '0;
      bus.bram_en <= 1'b0;
      bus.bram_we <= 1'b0;
      bus.bram_addr <= '0;
      bus.bram_din <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      rr_ptr <= rr_n;
      cnt <= cnt_n;
      bus.gnt <= gnt_n;
      bus.rvalid <= rvalid_n;
      bus.rdata <= rdata_n;
      bus.bram_en <= en_n;
      bus.bram_we <= we_n;
      bus.bram_addr <= addr_n;
      bus.bram_din <= din_n;
      busy <= state_n != IDLE;
    end
endmodule

// File: tb/tb_maze_bram_arbiter.sv
// tb_maze_bram_arbiter: directed checks of the maze BRAM arbiter at READ_LAT 1 and 3
module tb_maze_bram_arbiter;
  import maze_pkg::*;
  localparam int N = 3;
  logic mvmt_clk = 1'b0, reset = 1'b1, en = 1'b0;
  logic busy_a, busy_b;
  int checks = 0, errors = 0;
  logic pl_we = 1'b0, pl_sel = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_din = '0;
  logic [DATA_W-1:0] mem_a [256];
  logic [DATA_W-1:0] mem_b [256];
  logic [DATA_W-1:0] pipe_a;
  logic [DATA_W-1:0] pipe_b [3];
  always #5 mvmt_clk = ~mvmt_clk;
  maze_bram_arbiter_if #(.NUM_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) a ();
  maze_bram_arbiter_if #(.NUM_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) b ();
  maze_bram_arbiter #(.NUM_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(1)) dut_a (
    .mvmt_clk(mvmt_clk), .reset(reset), .en(en), .bus(a.slave), .busy(busy_a)
  );
  maze_bram_arbiter #(.NUM_REQ(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(3)) dut_b (
    .mvmt_clk(mvmt_clk), .reset(reset), .en(en), .bus(b.slave), .busy(busy_b)
  );
  // BRAM models: A returns data one cycle after the access, B three cycles after
  always @(posedge mvmt_clk) begin
    if (pl_we && !pl_sel) mem_a[pl_addr] <= pl_din;
    else if (a.bram_en && a.bram_we) mem_a[a.bram_addr] <= a.bram_din;
    if (a.bram_en && !a.bram_we) pipe_a <= mem_a[a.bram_addr];
    if (pl_we && pl_sel) mem_b[pl_addr] <= pl_din;
    else if (b.bram_en && b.bram_we) mem_b[b.bram_addr] <= b.bram_din;
    if (b.bram_en && !b.bram_we) pipe_b[0] <= mem_b[b.bram_addr];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign a.bram_dout = pipe_a;
  assign b.bram_dout = pipe_b[2];
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(negedge mvmt_clk);
  endtask
  task automatic preload(logic s, logic [ADDR_W-1:0] ad, logic [DATA_W-1:0] d);
    pl_sel = s;
    pl_addr = ad;
    pl_din = d;
    pl_we = 1'b1;
    step(1);
    pl_we = 1'b0;
  endtask
  task automatic req_a(int i, logic we, logic [ADDR_W-1:0] ad, logic [DATA_W-1:0] d);
    a.req_we[i] = we;
    a.req_addr[i*ADDR_W +: ADDR_W] = ad;
    a.req_din[i*DATA_W +: DATA_W] = d;
    a.req[i] = 1'b1;
  endtask
  function automatic int gidx(logic [N-1:0] g);
    return g == 3'b001 ? 0 : g == 3'b010 ? 1 : g == 3'b100 ? 2 : 7;
  endfunction
  initial begin
    int got [4];
    int ng, bad, lat;
    logic [N-1:0] seen;
    a.req = '0; a.req_we = '0; a.req_addr = '0; a.req_din = '0;
    b.req = '0; b.req_we = '0; b.req_addr = '0; b.req_din = '0;
    step(2);
    preload(1'b0, 8'h23, 9'h005);
    preload(1'b0, 8'h47, 9'h00B);
    preload(1'b1, 8'h10, 9'h0AB);
    check("rst_gnt", a.gnt, 0);
    check("rst_rvalid", a.rvalid, 0);
    check("rst_rdata", a.rdata, 0);
    check("rst_bram_en", a.bram_en, 0);
    check("rst_bram_we", a.bram_we, 0);
    check("rst_bram_addr", a.bram_addr, 0);
    check("rst_bram_din", a.bram_din, 0);
    check("rst_busy", busy_a, 0);
    reset = 1'b0;
    en = 1'b1;
    a.req_addr = {3{8'h23}};
    a.req = 3'b111;
    ng = 0;
    bad = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      step(1);
      if (a.gnt != '0) begin
        if (!$onehot(a.gnt)) bad++;
        got[ng] = gidx(a.gnt);
        ng++;
        if (ng == 4) a.req = '0;
      end
    end
    a.req = '0;
    check("rr_count", ng, 4);
    check("rr_onehot", bad, 0);
    for (int k = 0; k < 4; k++) check("rr_order", got[k], k % 3);
    step(4);
    check("rr_idle", busy_a, 0);
    req_a(0, 1'b0, 8'h23, 9'h000);
    step(1);
    check("rd_gnt", a.gnt, 3'b001);
    check("rd_addr", a.bram_addr, 8'h23);
    check("rd_en", a.bram_en, 1);
    check("rd_we", a.bram_we, 0);
    check("rd_busy", busy_a, 1);
    a.req = '0;
    step(1);
    check("rd_gnt_drop", a.gnt, 0);
    check("rd_en_drop", a.bram_en, 0);
    check("rd_rvalid_early", a.rvalid, 0);
    step(1);
    check("rd_rvalid", a.rvalid, 3'b001);
    check("rd_data", a.rdata, 9'h005);
    step(1);
    check("rd_rvalid_pulse", a.rvalid, 0);
    check("rd_hold", a.rdata, 9'h005);
    check("rd_idle", busy_a, 0);
    req_a(1, 1'b1, 8'h47, 9'h001);
    step(1);
    check("wr_gnt", a.gnt, 3'b010);
    check("wr_we", a.bram_we, 1);
    check("wr_addr", a.bram_addr, 8'h47);
    check("wr_din", a.bram_din, 9'h001);
    a.req = '0;
    step(1);
    check("wr_done", busy_a, 0);
    req_a(0, 1'b0, 8'h47, 9'h000);
    step(1);
    check("wr_rd_gnt", a.gnt, 3'b001);
    check("wr_no_rvalid", a.rvalid, 0);
    a.req = '0;
    step(2);
    check("wr_rd_rvalid", a.rvalid, 3'b001);
    check("wr_rd_data", a.rdata, 9'h001);
    step(1);
    req_a(0, 1'b0, 8'h23, 9'h000);
    step(1);
    check("en_gnt", a.gnt, 3'b001);
    en = 1'b0;
    a.req_we = '0;
    a.req = 3'b010;
    step(2);
    check("en_rvalid", a.rvalid, 3'b001);
    check("en_rdata", a.rdata, 9'h005);
    seen = '0;
    for (int c = 0; c < 4; c++) begin
      step(1);
      seen |= a.gnt;
    end
    check("en_hold_gnt", seen, 0);
    check("en_hold_idle", busy_a, 0);
    en = 1'b1;
    step(1);
    check("en_resume_gnt", a.gnt, 3'b010);
    a.req = '0;
    step(3);
    req_a(0, 1'b0, 8'h23, 9'h000);
    step(1);
    check("wd_gnt", a.gnt, 3'b001);
    a.req = 3'b100;
    step(1);
    a.req = '0;
    seen = '0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      seen |= a.gnt;
    end
    check("wd_never", seen, 0);
    a.req = 3'b011;
    step(1);
    check("wd_ptr", a.gnt, 3'b010);
    a.req = '0;
    step(3);
    b.req_addr = {3{8'h10}};
    b.req = 3'b001;
    step(1);
    check("b_gnt", b.gnt, 3'b001);
    b.req = '0;
    step(1);
    check("b_wait_busy", busy_b, 1);
    reset = 1'b1;
    #1;
    check("b_rst_busy", busy_b, 0);
    check("b_rst_gnt", b.gnt, 0);
    check("b_rst_en", b.bram_en, 0);
    check("b_rst_rvalid", b.rvalid, 0);
    seen = '0;
    for (int c = 0; c < 2; c++) begin
      step(1);
      seen |= b.rvalid;
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step(1);
      seen |= b.rvalid;
    end
    check("b_no_rvalid", seen, 0);
    b.req = 3'b111;
    step(1);
    check("b_first_gnt", b.gnt, 3'b001);
    b.req = '0;
    lat = 0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      step(1);
      if (b.rvalid != '0) lat = c;
    end
    check("b_rd_lat", lat, 4);
    check("b_rvalid", b.rvalid, 3'b001);
    check("b_rdata", b.rdata, 9'h0AB);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
